// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
//   8N1 asynchronous serial receiver with mid-bit sampling, start-bit glitch
//   rejection, framing-error detection with break handling, and a small
//   show-ahead FIFO popped by a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           serial line (idles high, asynchronous to clk)
//   clr_err      one-cycle pulse clearing framing_err and overrun
//   rx_ready     consumer takes rx_data this cycle
//   rx_data      byte at the FIFO head
//   rx_valid     FIFO not empty
//   rx_busy      frame in progress (any state other than idle)
//   framing_err  sticky: stop bit sampled low
//   overrun      sticky: a good byte was dropped because the FIFO was full
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_err,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic          framing_err_q;
  logic          overrun_q;

  logic stop_sample;
  logic fifo_full;
  logic pop;
  logic push;
  logic ovr_set;
  logic ferr_set;

  // Two-flop synchronizer; flops reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  // the byte without an overrun.
  always_comb begin
    stop_sample = (state_q == S_STOP) && (cnt_q == BIT_LAST);
    fifo_full   = (count_q == FULL_CNT);
    pop         = (count_q != '0) && rx_ready;
    push        = stop_sample && rx_s_q && (!fifo_full || pop);
    ovr_set     = stop_sample && rx_s_q && fifo_full && !pop;
    ferr_set    = stop_sample && !rx_s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_BREAK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line yields one framing error, not a string of frames.
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      framing_err_q <= ferr_set | (framing_err_q & ~clr_err);
      overrun_q     <= ovr_set  | (overrun_q & ~clr_err);
    end
  end

  always_comb begin
    rx_data     = mem_q[rd_ptr_q];
    rx_valid    = (count_q != '0);
    rx_busy     = (state_q != S_IDLE);
    framing_err = framing_err_q;
    overrun     = overrun_q;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8N1 asynchronous serial receiver. It is the receive-side counterpart of the SUBLEQ core's UART transmitter, and it supplies input characters to the core.
- Samples each bit at its mid-point, using a clock-cycle baud counter.
- Rejects start-bit glitches, detects framing errors.
- Buffers received bytes in a small show-ahead FIFO with a valid/ready pop handshake.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200); legal range 4..65535.
FIFO_DEPTH, 4, number of buffered bytes; power of 2, at least 2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  serial line; idles high; asynchronous to clk
clr_err  input  1  single-cycle pulse; clears framing_err and overrun
rx_ready  input  1  consumer accepts rx_data this cycle
rx_data  output  8  byte at the FIFO head (show-ahead)
rx_valid  output  1  FIFO not empty
rx_busy  output  1  a frame is in progress (state != IDLE)
framing_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a valid byte was dropped because the FIFO was full

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - Synchronizer flops = 1; state = IDLE; counters, shift register and FIFO pointers = 0.
  - rx_valid = 0, rx_data = 0, rx_busy = 0, framing_err = 0, overrun = 0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Input synchronizer: rx passes through 2 flops; rx_s is the second flop output. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2, integer division. The baud counter is sized to hold CLKS_PER_BIT-1.
- State IDLE:
  - When rx_s == 0, go to START and clear the counter.
  - The falling-edge cycle is t.
- State START:
  - Count up. At count == HALF-1 (sample at t+HALF), inspect rx_s.
  - rx_s == 0: go to DATA; counter = 0; bit index = 0.
  - rx_s == 1: glitch; return to IDLE with nothing recorded.
- State DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rx_s and clear the counter.
  - Shift right with the sample entering bit 7, so the LSB is received first.
  - Increment the bit index.
  - Bit k is sampled at t+HALF+(k+1)*CLKS_PER_BIT. After bit 7, go to STOP.
- State STOP: sample at t+HALF+9*CLKS_PER_BIT.
  - rx_s == 1 and FIFO not full (after accounting for a same-cycle pop): push the byte; go to IDLE.
  - rx_s == 1 and FIFO full with no same-cycle pop: discard the byte, set overrun, go to IDLE.
  - rx_s == 0: discard the byte, set framing_err, go to BREAK.
- State BREAK: wait for rx_s == 1, then go to IDLE. A held-low line (break) produces exactly one framing error, not repeated frames.
- FIFO:
  - rx_data = mem[rd_ptr]; rx_valid = (count != 0).
  - Pop occurs when rx_valid && rx_ready; rd_ptr advances at the clock edge.
  - After a push, rx_valid rises on the cycle after the stop-bit sample cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is held in a counter of width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle: occupancy is unchanged. This is allowed when the FIFO is full and does not set overrun.
  - rx_ready while empty has no effect.
- Sticky flags:
  - Cleared by clr_err.
  - If a set event and clr_err coincide, the flag ends up set.
  - Flags do not block reception.
- rx_busy = 1 in START, DATA, STOP and BREAK.

Test Plan:
1. Single byte: send 0xA5 8N1 at CLKS_PER_BIT=16 -> rx_valid rises once with rx_data=0xA5; framing_err=0; after a one-cycle rx_ready pulse, rx_valid=0.
2. Glitch: drive rx low for 4 cycles (CLKS_PER_BIT=16), then high -> rx_busy returns to 0 within HALF+3 cycles; no byte pushed; no flags set.
3. Framing error: send 0x3C with the stop bit low, then hold rx low for 40 cycles, then high; then send 0x55 -> framing_err=1, 0x3C not pushed, state stays in BREAK until release; 0x55 is then received correctly.
4. Overrun: send 0x01..0x05 back-to-back with rx_ready=0 (FIFO_DEPTH=4) -> overrun=1; pops yield 0x01,0x02,0x03,0x04 then rx_valid=0; a clr_err pulse clears overrun.
5. Full plus simultaneous pop: FIFO holds 4 bytes; assert rx_ready on the stop-sample cycle of 0x77 -> overrun stays 0; occupancy stays 4; the last pop returns 0x77.
6. Reset mid-frame: assert rst_n low during data bit 3, with 2 bytes buffered -> all outputs return to reset values; a subsequent 0xC3 frame is received correctly as the only FIFO entry.
